// File: rtl/bp_me_wormhole_mem_cmd_flit_tx.sv
// Purpose: serialises one encoded mem cmd packet into len+1 wormhole flits, flit 0 carrying cord and len.
// Latency: a packet accepted in cycle N presents flit 0 in cycle N+1; one idle cycle follows each packet's last flit.
// Backpressure: ready_i=0 holds the current flit and index; ready_o is high only while idle and never depends on v_i or ready_i.
module bp_me_wormhole_mem_cmd_flit_tx #(
  parameter int flit_width_p   = 64,
  parameter int cord_width_p   = 4,
  parameter int len_width_p    = 4,
  parameter int packet_width_p = 200
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [packet_width_p-1:0] packet_i,
  input  logic                      v_i,
  output logic                      ready_o,
  output logic [flit_width_p-1:0]   data_o,
  output logic                      v_o,
  input  logic                      ready_i
);

  localparam int max_flits_lp = (packet_width_p + flit_width_p - 1) / flit_width_p;
  localparam int pad_width_lp = max_flits_lp * flit_width_p;

  typedef enum logic {
    e_idle,
    e_send
  } state_e;

  state_e                  state_q, state_d;
  logic [pad_width_lp-1:0] pkt_q,   pkt_d;
  logic [len_width_p-1:0]  last_q,  last_d;
  logic [len_width_p-1:0]  idx_q,   idx_d;
  logic [31:0]             idx_ext;

  // Reset gates ready_o directly so it reads 0 for the whole time reset is held.
  assign ready_o = (state_q == e_idle) && !reset_i;
  assign v_o     = (state_q == e_send);

  // Shifting past the padded packet yields zero, which covers indices beyond max_flits_lp.
  assign idx_ext = 32'(idx_q);
  assign data_o  = flit_width_p'(pkt_q >> (idx_ext * flit_width_p));

  // Next-state: load on the idle handshake, advance the index on each accepted flit.
  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    last_d  = last_q;
    idx_d   = idx_q;
    case (state_q)
      e_idle: begin
        if (v_i && ready_o) begin
          pkt_d   = pad_width_lp'(packet_i);
          last_d  = packet_i[cord_width_p +: len_width_p];
          idx_d   = '0;
          state_d = e_send;
        end
      end
      e_send: begin
        if (ready_i) begin
          if (idx_q == last_q) begin
            state_d = e_idle;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = e_idle;
    endcase
  end

  // State registers; reset abandons any packet in flight.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= e_idle;
      pkt_q   <= '0;
      last_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: doc/bp_me_wormhole_mem_cmd_flit_tx.md
BP_ME_WORMHOLE_MEM_CMD_FLIT_TX -- requirements
Module: bp_me_wormhole_mem_cmd_flit_tx

Interface
REQ-001 Parameter flit_width_p, "inv", width of one wormhole flit in bits.
REQ-002 Parameter cord_width_p, "inv", width of the destination cord field at packet bits [cord_width_p-1:0].
REQ-003 Parameter len_width_p, "inv", width of the length field at packet bits [cord_width_p+len_width_p-1:cord_width_p].
REQ-004 Parameter packet_width_p, "inv", width of the encoded mem cmd packet {payload, len, cord}.
REQ-005 Localparam max_flits_lp = ceil(packet_width_p/flit_width_p); packet is zero-padded to max_flits_lp*flit_width_p.
REQ-006 Port clk_i input 1: the single clock; all state is updated on its rising edge.
REQ-007 Port reset_i input 1: asynchronous, active-high reset.
REQ-008 Port packet_i input packet_width_p: encoded packet from the mem cmd encoder.
REQ-009 Port v_i input 1: packet_i valid.
REQ-010 Port ready_o output 1: block can accept a packet this cycle.
REQ-011 Port data_o output flit_width_p: current flit.
REQ-012 Port v_o output 1: data_o valid.
REQ-013 Port ready_i input 1: downstream link accepts the flit.

Function
REQ-014 Two states: IDLE and SEND.
REQ-015 ready_o is 1 in IDLE and 0 in SEND; ready_o never depends combinationally on ready_i or v_i.
REQ-016 In IDLE, v_i&ready_o captures packet_i into a packet register, captures len into a last-index register, clears the flit index to 0 and moves to SEND next cycle.
REQ-017 Latency: a packet accepted in cycle N has its flit 0 on data_o with v_o=1 in cycle N+1.
REQ-018 In SEND, v_o=1 and data_o = packet_r[index*flit_width_p +: flit_width_p]; v_o never depends on ready_i.
REQ-019 In SEND, v_o&ready_i advances: if index==last then go to IDLE, else index increments by 1.
REQ-020 Exactly len+1 flits are emitted per packet; flit 0 carries the cord and len fields.
REQ-021 While v_o=1 and ready_i=0, data_o and the index hold unchanged.
REQ-022 Flit indices >= max_flits_lp drive data_o to all zeros and are still emitted and counted.
REQ-023 The index counter is len_width_p bits wide; len = 2^len_width_p-1 terminates correctly with no wrap.
REQ-024 One idle bubble cycle separates packets: after the last flit handshake, ready_o=1 in the next cycle and the next flit 0 appears no earlier than two cycles after that handshake.
REQ-025 v_i asserted while ready_o=0 is ignored; the packet register does not change.
REQ-026 The packet register and last-index register load only on the REQ-016 handshake.

Reset
REQ-027 While reset_i=1, asynchronously: state=IDLE, index=0, v_o=0, ready_o=0.
REQ-028 After reset_i deasserts, ready_o=1 from the first clock edge onward.
REQ-029 data_o while v_o=0 has no required value; a bench does not check it.
REQ-030 Reset asserted mid-packet discards the remaining flits; no flit of that packet is emitted after reset.

Verification
REQ-031 flit=64, cord=4, len=4, packet=200; packet with len=0, ready_i=1 -> one flit equal to packet[63:0], ready_o returns to 1 the following cycle.
REQ-032 Same parameters, len=3, ready_i toggled 1,0,0,1,1,0,1 -> four flits packet[63:0], [127:64], [191:128], {56'b0, packet[199:192]} in order; data_o is stable during the stalls.
REQ-033 len=5 with max_flits_lp=4 -> six flits; flits 4 and 5 are all zeros.
REQ-034 Reset asserted after flit 1 of a len=3 packet -> v_o=0 immediately; after release, a new len=1 packet yields exactly 2 correct flits.
REQ-035 v_i held high with packets A then B and ready_i=1 -> A's flits, then one v_o=0 bubble cycle, then B's flits; B is sampled only when ready_o=1.
REQ-036 len=15 (maximum) -> exactly 16 flits emitted, then a return to IDLE.
